// File: rtl/e203_exu_flush_arb_pkg.sv
// e203_exu_flush_arb_pkg: shared state and owner encodings for the flush arbiter.
package e203_flush_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef enum logic {OWN_BRCH = 1'b0, OWN_EXCP = 1'b1} owner_e;
endpackage

// File: rtl/e203_exu_flush_arb_if.sv
// e203_exu_flush_arb_if: requester/IFU flush bus; E203_FLUSH_ARB_PC_EN adds the PC fields.
interface e203_exu_flush_arb_if #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 16
);
  logic               excp_flush_req;
  logic               brch_flush_req;
  logic [PC_SIZE-1:0] excp_flush_op1;
  logic [PC_SIZE-1:0] excp_flush_op2;
  logic [PC_SIZE-1:0] brch_flush_op1;
  logic [PC_SIZE-1:0] brch_flush_op2;
  logic               excp_flush_ack;
  logic               brch_flush_ack;
  logic               pipe_flush_req;
  logic [PC_SIZE-1:0] pipe_flush_add_op1;
  logic [PC_SIZE-1:0] pipe_flush_add_op2;
  logic               pipe_flush_ack;
  logic               flush_pulse;
  logic               flush_owner_excp;
  logic               cnt_clr;
  logic [CNT_W-1:0]   flush_cnt;
`ifdef E203_FLUSH_ARB_PC_EN
  logic [PC_SIZE-1:0] excp_flush_pc;
  logic [PC_SIZE-1:0] brch_flush_pc;
  logic [PC_SIZE-1:0] pipe_flush_pc;
`endif
  modport slave (
`ifdef E203_FLUSH_ARB_PC_EN
    input  excp_flush_pc, brch_flush_pc,
    output pipe_flush_pc,
`endif
    input  excp_flush_req, brch_flush_req,
    input  excp_flush_op1, excp_flush_op2, brch_flush_op1, brch_flush_op2,
    output excp_flush_ack, brch_flush_ack,
    output pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
    input  pipe_flush_ack,
    output flush_pulse, flush_owner_excp,
    input  cnt_clr,
    output flush_cnt
  );
  modport master (
`ifdef E203_FLUSH_ARB_PC_EN
    output excp_flush_pc, brch_flush_pc,
    input  pipe_flush_pc,
`endif
    output excp_flush_req, brch_flush_req,
    output excp_flush_op1, excp_flush_op2, brch_flush_op1, brch_flush_op2,
    input  excp_flush_ack, brch_flush_ack,
    input  pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
    output pipe_flush_ack,
    input  flush_pulse, flush_owner_excp,
    output cnt_clr,
    input  flush_cnt
  );
endinterface

// File: rtl/e203_exu_flush_arb_prio.sv
// e203_flush_prio_arb: fixed-priority one-hot grant, req[1] (excp) beats req[0] (brch).
module e203_flush_prio_arb (
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  assign gnt = {req[1], req[0] & ~req[1]};
endmodule

// File: rtl/e203_exu_flush_arb.sv
// e203_exu_flush_arb: two-requester non-preemptive flush arbiter toward the IFU; optional PC path under E203_FLUSH_ARB_PC_EN.
module e203_exu_flush_arb
  import e203_flush_pkg::*;
#(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  e203_exu_flush_arb_if.slave bus
);
  state_e             state;
  owner_e             owner;
  logic [PC_SIZE-1:0] op1, op2;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         gnt;
  logic               busy, hs, take;
`ifdef E203_FLUSH_ARB_PC_EN
  logic [PC_SIZE-1:0] pc;
`endif
  e203_flush_prio_arb u_prio (
    .req({bus.excp_flush_req, bus.brch_flush_req}),
    .gnt(gnt)
  );
  // rst gates the handshake so a flush pending at reset never acks
  assign busy = (state == BUSY) & ~rst;
  assign hs   = busy & bus.pipe_flush_ack;
  assign take = (state == IDLE) & (|gnt);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_BRCH;
      op1   <= '0;
      op2   <= '0;
`ifdef E203_FLUSH_ARB_PC_EN
      pc    <= '0;
`endif
    end else begin
      state <= (state == IDLE) ? (take ? BUSY : IDLE) : (bus.pipe_flush_ack ? IDLE : BUSY);
      owner <= take ? (gnt[1] ? OWN_EXCP : OWN_BRCH) : owner;
      op1   <= take ? (gnt[1] ? bus.excp_flush_op1 : bus.brch_flush_op1) : op1;
      op2   <= take ? (gnt[1] ? bus.excp_flush_op2 : bus.brch_flush_op2) : op2;
`ifdef E203_FLUSH_ARB_PC_EN
      pc    <= take ? (gnt[1] ? bus.excp_flush_pc : bus.brch_flush_pc) : pc;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst | bus.cnt_clr) cnt <= '0;
    else if (hs & ~&cnt) cnt <= cnt + 1'b1;
  end
  assign bus.pipe_flush_req     = busy;
  assign bus.flush_pulse        = hs;
  assign bus.excp_flush_ack     = hs & (owner == OWN_EXCP);
  assign bus.brch_flush_ack     = hs & (owner == OWN_BRCH);
  assign bus.flush_owner_excp   = (owner == OWN_EXCP);
  assign bus.pipe_flush_add_op1 = op1;
  assign bus.pipe_flush_add_op2 = op2;
  assign bus.flush_cnt          = cnt;
`ifdef E203_FLUSH_ARB_PC_EN
  assign bus.pipe_flush_pc      = pc;
`endif
endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// tb_e203_exu_flush_arb: directed scenarios plus random traffic against a transaction-level model.
module tb_e203_exu_flush_arb;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk, rst;
  int   n_vec, n_err;
  e203_exu_flush_arb_if #(.PC_SIZE(32), .CNT_W(CW)) bus ();
  e203_exu_flush_arb #(.PC_SIZE(32), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  bit          m_busy, m_excp;
  logic [31:0] m_op1, m_op2, m_pc;
  int          m_cnt;
  bit          seen_excp_ack, seen_brch_ack;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    bit p;
    #1;
    p = m_busy && !rst && bus.pipe_flush_ack;
    check("pipe_req", 64'(bus.pipe_flush_req), 64'(m_busy && !rst));
    check("pulse", 64'(bus.flush_pulse), 64'(p));
    check("excp_ack", 64'(bus.excp_flush_ack), 64'(p && m_excp));
    check("brch_ack", 64'(bus.brch_flush_ack), 64'(p && !m_excp));
    check("owner", 64'(bus.flush_owner_excp), 64'(m_excp));
    check("op1", 64'(bus.pipe_flush_add_op1), 64'(m_op1));
    check("op2", 64'(bus.pipe_flush_add_op2), 64'(m_op2));
    check("cnt", 64'(bus.flush_cnt), 64'(m_cnt));
`ifdef E203_FLUSH_ARB_PC_EN
    check("pc", 64'(bus.pipe_flush_pc), 64'(m_pc));
`endif
    seen_excp_ack = bus.excp_flush_ack;
    seen_brch_ack = bus.brch_flush_ack;
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_excp = 0; m_op1 = 0; m_op2 = 0; m_pc = 0; m_cnt = 0;
    end else begin
      m_cnt = bus.cnt_clr ? 0 : (p ? ((m_cnt == CMAX) ? CMAX : m_cnt + 1) : m_cnt);
      if (m_busy) m_busy = !bus.pipe_flush_ack;
      else if (bus.excp_flush_req) begin
        m_busy = 1; m_excp = 1; m_op1 = bus.excp_flush_op1; m_op2 = bus.excp_flush_op2;
`ifdef E203_FLUSH_ARB_PC_EN
        m_pc = bus.excp_flush_pc;
`endif
      end else if (bus.brch_flush_req) begin
        m_busy = 1; m_excp = 0; m_op1 = bus.brch_flush_op1; m_op2 = bus.brch_flush_op2;
`ifdef E203_FLUSH_ARB_PC_EN
        m_pc = bus.brch_flush_pc;
`endif
      end
    end
    @(negedge clk);
  endtask
  task automatic set_excp(input bit r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    bus.excp_flush_req = r; bus.excp_flush_op1 = a; bus.excp_flush_op2 = b;
`ifdef E203_FLUSH_ARB_PC_EN
    bus.excp_flush_pc = pc;
`else
    if (pc != 0) m_pc = 0;
`endif
  endtask
  task automatic set_brch(input bit r, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    bus.brch_flush_req = r; bus.brch_flush_op1 = a; bus.brch_flush_op2 = b;
`ifdef E203_FLUSH_ARB_PC_EN
    bus.brch_flush_pc = pc;
`else
    if (pc != 0) m_pc = 0;
`endif
  endtask
  initial begin
    n_vec = 0; n_err = 0;
    m_busy = 0; m_excp = 0; m_op1 = 0; m_op2 = 0; m_pc = 0; m_cnt = 0;
    rst = 1;
    set_excp(0, 0, 0, 0);
    set_brch(0, 0, 0, 0);
    bus.pipe_flush_ack = 0; bus.cnt_clr = 0;
    @(negedge clk); @(negedge clk);
    bus.brch_flush_req = 1; bus.pipe_flush_ack = 1;
    tick(); tick();
    check("rst_pipe_req", 64'(bus.pipe_flush_req), 0);
    check("rst_cnt", 64'(bus.flush_cnt), 0);
    bus.brch_flush_req = 0; bus.pipe_flush_ack = 0; rst = 0;
    tick();
    // single branch flush with ack tied high
    set_brch(1, 32'h8000_0100, 32'h10, 32'h0000_0300);
    bus.pipe_flush_ack = 1;
    tick();
    #1;
    check("b1_req", 64'(bus.pipe_flush_req), 1);
    check("b1_op1", 64'(bus.pipe_flush_add_op1), 64'h8000_0100);
    check("b1_op2", 64'(bus.pipe_flush_add_op2), 64'h10);
    check("b1_brch_ack", 64'(bus.brch_flush_ack), 1);
    check("b1_pulse", 64'(bus.flush_pulse), 1);
    tick();
    set_brch(0, 0, 0, 0);
    #1 check("b1_cnt", 64'(bus.flush_cnt), 1);
    check("b1_idle_op1", 64'(bus.pipe_flush_add_op1), 64'h8000_0100);
    tick();
    // simultaneous requests: excp first, brch right after
    set_excp(1, 32'h1111_0000, 32'h4, 32'h0000_0400);
    set_brch(1, 32'h2222_0000, 32'h8, 32'h0000_0500);
    tick();
    #1 check("both_owner", 64'(bus.flush_owner_excp), 1);
    check("both_excp_ack", 64'(bus.excp_flush_ack), 1);
    check("both_brch_ack", 64'(bus.brch_flush_ack), 0);
    tick();
    set_excp(0, 0, 0, 0);
    tick();
    #1 check("both2_owner", 64'(bus.flush_owner_excp), 0);
    check("both2_op1", 64'(bus.pipe_flush_add_op1), 64'h2222_0000);
    tick();
    set_brch(0, 0, 0, 0);
    tick();
    // branch held off for 5 cycles, excp arrives mid-flight
    bus.pipe_flush_ack = 0;
    set_brch(1, 32'h3333_0000, 32'hC, 32'h0000_0600);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) set_excp(1, 32'h4444_0000, 32'h20, 32'h0000_0200);
      if (i == 2) set_brch(1, 32'hDEAD_BEEF, 32'h1, 32'h0000_0700);
      #1 check("hold_op1", 64'(bus.pipe_flush_add_op1), 64'h3333_0000);
      check("hold_owner", 64'(bus.flush_owner_excp), 0);
      tick();
    end
    bus.pipe_flush_ack = 1;
    tick();
    set_brch(0, 0, 0, 0);
    tick();
    #1 check("late_excp_owner", 64'(bus.flush_owner_excp), 1);
    check("late_excp_op1", 64'(bus.pipe_flush_add_op1), 64'h4444_0000);
    tick();
    set_excp(0, 0, 0, 0);
    bus.pipe_flush_ack = 0;
    tick();
    // ack while idle must be ignored
    bus.pipe_flush_ack = 1;
    tick(); tick();
    // saturate the counter, then clear coincident with a handshake
    bus.cnt_clr = 1; tick(); bus.cnt_clr = 0;
    set_brch(1, 32'h5555_0000, 32'h2, 32'h0);
    for (int i = 0; i < 2 * CMAX + 8; i++) tick();
    #1 check("sat_cnt", 64'(bus.flush_cnt), 64'(CMAX));
    for (int i = 0; i < 3 && !bus.pipe_flush_req; i++) tick();
    #1 check("sat_busy", 64'(bus.pipe_flush_req), 1);
    bus.cnt_clr = 1;
    tick();
    bus.cnt_clr = 0;
    set_brch(0, 0, 0, 0);
    #1 check("clr_hs_cnt", 64'(bus.flush_cnt), 0);
    tick(); tick();
    // reset while busy abandons the flush
    bus.pipe_flush_ack = 0;
    set_excp(1, 32'h6666_0000, 32'h40, 32'h0000_0200);
    tick();
    #1 check("pre_rst_req", 64'(bus.pipe_flush_req), 1);
`ifdef E203_FLUSH_ARB_PC_EN
    check("excp_pc", 64'(bus.pipe_flush_pc), 64'h0000_0200);
`endif
    tick();
    rst = 1; bus.pipe_flush_ack = 1;
    #1 check("rst_busy_ack", 64'(bus.excp_flush_ack), 0);
    tick();
    rst = 0; bus.pipe_flush_ack = 0;
    set_excp(0, 0, 0, 0);
    #1 check("post_rst_req", 64'(bus.pipe_flush_req), 0);
    check("post_rst_cnt", 64'(bus.flush_cnt), 0);
    tick();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (bus.excp_flush_req && (seen_excp_ack || $urandom_range(0, 19) == 0)) set_excp(0, 0, 0, 0);
      else if (!bus.excp_flush_req && $urandom_range(0, 3) == 0) set_excp(1, $urandom, $urandom, $urandom);
      else if (bus.excp_flush_req && $urandom_range(0, 9) == 0) set_excp(1, $urandom, $urandom, $urandom);
      if (bus.brch_flush_req && (seen_brch_ack || $urandom_range(0, 19) == 0)) set_brch(0, 0, 0, 0);
      else if (!bus.brch_flush_req && $urandom_range(0, 2) == 0) set_brch(1, $urandom, $urandom, $urandom);
      else if (bus.brch_flush_req && $urandom_range(0, 9) == 0) set_brch(1, $urandom, $urandom, $urandom);
      bus.pipe_flush_ack = 1'($urandom_range(0, 1));
      bus.cnt_clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/e203_exu_flush_arb.md
E203_EXU_FLUSH_ARB -- requirements
Module: e203_exu_flush_arb

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, width of flush adder operands and PC.
REQ-002 SHALL have parameter CNT_W, default 16, width of the flush event counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports excp_flush_req / brch_flush_req  input  1 each  flush request from the exception/IRQ unit and the branch-resolve unit.
REQ-006 SHALL have ports excp_flush_op1, excp_flush_op2, brch_flush_op1, brch_flush_op2  input  PC_SIZE each  flush adder operands.
REQ-007 SHALL have ports excp_flush_ack / brch_flush_ack  output  1 each  per-requester handshake completion.
REQ-008 SHALL have ports pipe_flush_req  output  1; pipe_flush_add_op1, pipe_flush_add_op2  output  PC_SIZE; pipe_flush_ack  input  1  flush interface to IFU.
REQ-009 SHALL have ports flush_pulse  output  1  (handshake strobe); flush_owner_excp  output  1  (1 = current grant is exception); cnt_clr  input  1; flush_cnt  output  CNT_W.

Function
REQ-010 SHALL implement two states: IDLE and BUSY.
REQ-011 In IDLE, if either request is high, SHALL grant with fixed priority excp over brch, register the winner's op1/op2 and owner, and enter BUSY on the next edge.
REQ-012 SHALL assert pipe_flush_req only in BUSY; latency from request sampled in IDLE to pipe_flush_req high SHALL be exactly 1 cycle.
REQ-013 In BUSY, pipe_flush_add_op1/op2 and flush_owner_excp SHALL hold stable until pipe_flush_ack is sampled high.
REQ-014 SHALL not preempt: an excp request arriving while brch owns BUSY waits until the brch handshake completes.
REQ-015 Handshake = BUSY & pipe_flush_ack; flush_pulse SHALL equal it combinationally; owner's *_flush_ack SHALL pulse in the same cycle; non-owner ack SHALL stay 0.
REQ-016 On handshake SHALL return to IDLE; a new grant can occur no earlier than the following cycle (minimum 2 cycles per flush).
REQ-017 Requesters SHALL keep their req and operands stable until their ack; arbiter SHALL ignore operand changes after capture.
REQ-018 Request dropped by its owner before ack SHALL not cancel BUSY; flush completes with captured payload.
REQ-019 pipe_flush_ack in IDLE SHALL be ignored (no pulse, no count).
REQ-020 flush_cnt SHALL increment by 1 per handshake and saturate at all-ones; cnt_clr SHALL zero it next cycle; cnt_clr with simultaneous handshake SHALL yield 0.
REQ-021 In IDLE, pipe_flush_add_op1/op2 SHALL hold their last captured values (no toggling).

Reset
REQ-022 rst SHALL force IDLE, owner=0, op registers=0, flush_cnt=0; outputs pipe_flush_req, flush_pulse, both acks = 0 during and after reset.
REQ-023 rst asserted in BUSY SHALL abandon the pending flush with no ack issued.

Configuration
REQ-024 Macro E203_FLUSH_ARB_PC_EN, when defined, SHALL add inputs excp_flush_pc, brch_flush_pc (PC_SIZE) and output pipe_flush_pc, captured and held with op1/op2 per REQ-011/013, reset 0.
REQ-025 Without E203_FLUSH_ARB_PC_EN those ports and registers SHALL be absent; all other behaviour identical.

Structure
REQ-026 Shared package e203_flush_pkg SHALL hold the state enum (IDLE, BUSY) and owner enum (OWN_BRCH=0, OWN_EXCP=1).
REQ-027 Fixed-priority selection SHALL be a combinational sub-module e203_flush_prio_arb (2 requests in, one-hot grant out).

Verification
REQ-028 brch_req=1, op1=0x8000_0100, op2=0x10, ack tied 1 -> pipe_flush_req high 1 cycle later with those ops, brch_ack and flush_pulse 1 cycle, flush_cnt=1.
REQ-029 excp_req and brch_req both high in same IDLE cycle -> excp granted first (owner_excp=1), brch granted the cycle after excp handshake returns IDLE.
REQ-030 brch granted, ack held 0 for 5 cycles, excp_req raised cycle 2 -> ops stable 5 cycles, no preemption, excp served after brch ack.
REQ-031 flush_cnt preloaded to 0xFFFF via repeated flushes -> stays 0xFFFF; cnt_clr with coincident handshake -> 0.
REQ-032 rst pulsed while BUSY with ack=0 -> next cycle IDLE, pipe_flush_req=0, no ack pulse, flush_cnt=0.
REQ-033 Build with E203_FLUSH_ARB_PC_EN, excp_pc=0x0000_0200 -> pipe_flush_pc=0x0000_0200 alongside excp ops until ack.
